axburst_partitioner: RTL and testbench



---
 rtl/axburst_partitioner_if.sv | 55 +++++
 rtl/axburst_partitioner.sv | 198 +++++++++++++++++++
 tb/tb_axburst_partitioner.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axburst_partitioner_if.sv
// axburst_partitioner_if
//   Bundles the job, address and response-monitor signals of the burst
//   partitioner.
//   Modports:
//     master - the partitioner. It is the AXI address master and receives
//              the DMA job.
//     slave  - the environment. It offers jobs, accepts addresses and
//              returns responses.
//   Signals:
//     dma_valid/dma_ready, dma_sa, dma_len, dma_irq_w1c, dma_irq, dma_err
//     axid, axaddr, axlen, axsize, axburst, axvalid/axready
//     rsp_id, rsp_resp, rsp_last, rsp_valid/rsp_ready (observed only)
interface axburst_partitioner_if #(
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8
);
    logic              dma_valid;
    logic              dma_ready;
    logic [31:0]       dma_sa;
    logic [31:0]       dma_len;
    logic              dma_irq_w1c;
    logic              dma_irq;
    logic [3:0]        dma_err;

    logic [AXI_IW-1:0] axid;
    logic [AXI_AW-1:0] axaddr;
    logic [AXI_LW-1:0] axlen;
    logic [2:0]        axsize;
    logic [1:0]        axburst;
    logic              axvalid;
    logic              axready;

    logic [AXI_IW-1:0] rsp_id;
    logic [1:0]        rsp_resp;
    logic              rsp_last;
    logic              rsp_valid;
    logic              rsp_ready;

    modport master (
        input  dma_valid, dma_sa, dma_len, dma_irq_w1c,
        input  axready,
        input  rsp_id, rsp_resp, rsp_last, rsp_valid, rsp_ready,
        output dma_ready, dma_irq, dma_err,
        output axid, axaddr, axlen, axsize, axburst, axvalid
    );

    modport slave (
        output dma_valid, dma_sa, dma_len, dma_irq_w1c,
        output axready,
        output rsp_id, rsp_resp, rsp_last, rsp_valid, rsp_ready,
        input  dma_ready, dma_irq, dma_err,
        input  axid, axaddr, axlen, axsize, axburst, axvalid
    );
endinterface

// File: rtl/axburst_partitioner.sv
// axburst_partitioner
//   Splits a byte-granular DMA transfer into AXI INCR bursts. No burst
//   crosses a BL-word boundary. At most MAX_OST bursts are outstanding at
//   once. Completions are counted from the observed B/R response stream.
//   The block raises dma_irq when the job has finished. Error status in
//   dma_err is sticky until dma_irq_w1c is written in DONE.
//   Ports:
//     clk     - clock
//     reset_n - synchronous active-low reset
//     bus     - axburst_partitioner_if.master (job, AW/AR, response monitor)
//   Optional feature:
//     AXBURST_PART_TIMEOUT_EN - watchdog. It sets dma_err[3] and forces
//     DONE after TO_CYCLES idle cycles in BUSY/RESP.
module axburst_partitioner #(
    parameter int AXI_DW    = 128,
    parameter int AXI_AW    = 32,
    parameter int AXI_IW    = 8,
    parameter int AXI_LW    = 8,
    parameter int BL        = 16,
    parameter int ID_BASE   = 0,
    parameter int ID_NUM    = 4,
    parameter int MAX_OST   = 4,
    parameter int TO_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axburst_partitioner_if.master bus
);
    localparam int AXI_BYTES = AXI_DW / 8;
    localparam int L         = $clog2(AXI_BYTES);
    localparam int LBL       = $clog2(BL);
    localparam int IDW       = (ID_NUM > 1) ? $clog2(ID_NUM) : 1;
    localparam int OSTW      = $clog2(MAX_OST + 1);
    localparam int WAW       = AXI_AW - L;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

    state_t          state_reg, state_next;
    logic [WAW-1:0]  addr_reg, addr_next;   // word address of next burst
    logic [32:0]     words_reg, words_next; // words still to issue
    logic [OSTW-1:0] ost_reg, ost_next;
    logic [IDW-1:0]  id_reg, id_next;
    logic [3:0]      err_reg, err_next;

    logic            busy;
    logic            issue;
    logic            beat;
    logic            cmpl;
    logic            cmpl_ok;
    logic            id_bad;
    logic            last_burst;
    logic            timeout_hit;
    logic [LBL:0]    room;
    logic [LBL:0]    beats;
    logic [AXI_IW:0] id_off;
    logic [32:0]     word_cnt;

    assign busy    = (state_reg == BUSY);
    assign issue   = bus.axvalid & bus.axready;
    assign beat    = bus.rsp_valid & bus.rsp_ready;
    assign cmpl    = beat & bus.rsp_last;
    // A completion with nothing outstanding is unexpected. It must not
    // underflow the counter.
    assign cmpl_ok = cmpl && (ost_reg != '0);

    // An ID below ID_BASE wraps to a large offset, so a single compare
    // covers both ends of the window.
    assign id_off = {1'b0, bus.rsp_id} - (AXI_IW + 1)'(ID_BASE);
    assign id_bad = (id_off >= (AXI_IW + 1)'(ID_NUM));

    // Beats left before the next BL-word boundary, clipped to the words
    // still owed.
    assign room       = (LBL + 1)'(BL) - {1'b0, addr_reg[LBL-1:0]};
    assign beats      = (words_reg < 33'(room)) ? words_reg[LBL:0] : room;
    assign last_burst = (words_reg == 33'(beats));

    // Head offset plus length, rounded up to whole words. The width is
    // 33 bits so that a maximal length cannot overflow.
    assign word_cnt = (33'(bus.dma_sa[L-1:0]) + {1'b0, bus.dma_len}
                       + 33'(AXI_BYTES - 1)) >> L;

    assign bus.dma_ready = (state_reg == IDLE);
    assign bus.dma_irq   = (state_reg == DONE);
    assign bus.dma_err   = err_reg;
    assign bus.axsize    = 3'(L);
    assign bus.axburst   = 2'b01;
    // These outputs are held at zero outside BUSY, so the bus is quiet
    // between jobs.
    assign bus.axvalid   = busy && (ost_reg < OSTW'(MAX_OST));
    assign bus.axaddr    = busy ? {addr_reg, {L{1'b0}}} : '0;
    assign bus.axlen     = busy ? AXI_LW'(beats - 1'b1) : '0;
    assign bus.axid      = busy ? (AXI_IW'(ID_BASE) + AXI_IW'(id_reg)) : '0;

`ifdef AXBURST_PART_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYCLES + 1);
    logic [TOW-1:0] to_cnt_reg, to_cnt_next;

    // The count restarts on any address handshake or completion. It is
    // held at zero outside BUSY/RESP.
    always_comb begin
        to_cnt_next = '0;
        timeout_hit = 1'b0;
        if ((state_reg == BUSY || state_reg == RESP) && !(issue || cmpl)) begin
            to_cnt_next = to_cnt_reg + 1'b1;
            timeout_hit = (to_cnt_next == TOW'(TO_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= timeout_hit ? '0 : to_cnt_next;
    end
`else
    // There is no watchdog. This compare folds to a constant 0.
    assign timeout_hit = (TO_CYCLES < 0);
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        words_next = words_reg;
        id_next    = id_reg;
        err_next   = err_reg;
        ost_next   = ost_reg;

        if (issue && !cmpl_ok)
            ost_next = ost_reg + 1'b1;
        else if (!issue && cmpl_ok)
            ost_next = ost_reg - 1'b1;

        if (beat && (bus.rsp_resp != 2'b00) && (err_reg[1:0] == 2'b00))
            err_next[1:0] = bus.rsp_resp;
        if ((beat && id_bad) || (cmpl && !cmpl_ok))
            err_next[2] = 1'b1;

        case (state_reg)
            IDLE: begin
                if (bus.dma_valid) begin
                    if (bus.dma_len == '0) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = bus.dma_sa[AXI_AW-1:L];
                        words_next = word_cnt;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (issue) begin
                    addr_next  = addr_reg + WAW'(beats);
                    words_next = words_reg - 33'(beats);
                    id_next    = (id_reg == IDW'(ID_NUM - 1)) ? '0 : id_reg + 1'b1;
                    if (last_burst)
                        state_next = (ost_next == '0) ? DONE : RESP;
                end
            end
            RESP: begin
                if (ost_next == '0)
                    state_next = DONE;
            end
            DONE: begin
                if (bus.dma_irq_w1c) begin
                    state_next = IDLE;
                    err_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // The watchdog ends the job. Completions that arrive later are
        // treated as unexpected.
        if (timeout_hit) begin
            state_next  = DONE;
            ost_next    = '0;
            err_next[3] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            words_reg <= '0;
            ost_reg   <= '0;
            id_reg    <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            words_reg <= words_next;
            ost_reg   <= ost_next;
            id_reg    <= id_next;
            err_reg   <= err_next;
        end
    end
endmodule

// File: tb/tb_axburst_partitioner.sv
// tb_axburst_partitioner
//   Directed bench for axburst_partitioner with MAX_OST=2. All other
//   parameters are defaults: 16-byte words, BL=16, 4 IDs from 0.
//   Stimulus is driven 1 time unit after the rising edge. Outputs are
//   checked after the inputs settle. Each check prints one line only
//   when it fails.
module tb_axburst_partitioner;
    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    axburst_partitioner_if #(.AXI_AW(32), .AXI_IW(8), .AXI_LW(8)) bus ();

    axburst_partitioner #(.MAX_OST(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input logic v, input logic [7:0] id, input logic [1:0] resp, input logic last);
        bus.rsp_valid = v;
        bus.rsp_id    = id;
        bus.rsp_resp  = resp;
        bus.rsp_last  = last;
    endtask

    task automatic job(input logic [31:0] sa, input logic [31:0] len);
        bus.dma_sa    = sa;
        bus.dma_len   = len;
        bus.dma_valid = 1'b1;
        tick();
        bus.dma_valid = 1'b0;
    endtask

    task automatic w1c();
        bus.dma_irq_w1c = 1'b1;
        tick();
        bus.dma_irq_w1c = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.dma_valid   = 1'b0;
        bus.dma_sa      = '0;
        bus.dma_len     = '0;
        bus.dma_irq_w1c = 1'b0;
        bus.axready     = 1'b1;
        bus.rsp_ready   = 1'b1;
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        tick();
        tick();

        // Reset state
        chk("rst_dma_ready", bus.dma_ready, 1);
        chk("rst_dma_irq",   bus.dma_irq, 0);
        chk("rst_dma_err",   bus.dma_err, 0);
        chk("rst_axvalid",   bus.axvalid, 0);
        chk("rst_axaddr",    bus.axaddr, 0);
        chk("rst_axlen",     bus.axlen, 0);
        chk("rst_axid",      bus.axid, 0);
        chk("rst_axsize",    bus.axsize, 4);
        chk("rst_axburst",   bus.axburst, 1);
        reset_n = 1'b1;
        tick();

        // Aligned 1 KiB job: four 16-beat bursts with IDs 0..3.
        job(32'h1000, 32'h400);
        chk("t1_b0_valid", bus.axvalid, 1);
        chk("t1_b0_addr",  bus.axaddr, 32'h1000);
        chk("t1_b0_len",   bus.axlen, 15);
        chk("t1_b0_id",    bus.axid, 0);
        chk("t1_busy_rdy", bus.dma_ready, 0);
        tick();
        chk("t1_b1_addr",  bus.axaddr, 32'h1100);
        chk("t1_b1_id",    bus.axid, 1);
        tick();
        chk("t1_throttle", bus.axvalid, 0);
        rsp(1'b1, 8'd0, 2'b00, 1'b1);
        tick();
        chk("t1_b2_valid", bus.axvalid, 1);
        chk("t1_b2_addr",  bus.axaddr, 32'h1200);
        chk("t1_b2_id",    bus.axid, 2);
        rsp(1'b1, 8'd1, 2'b00, 1'b1);
        tick();
        chk("t1_b3_addr",  bus.axaddr, 32'h1300);
        chk("t1_b3_len",   bus.axlen, 15);
        chk("t1_b3_id",    bus.axid, 3);
        rsp(1'b1, 8'd2, 2'b00, 1'b1);
        tick();
        chk("t1_resp_valid", bus.axvalid, 0);
        chk("t1_resp_irq",   bus.dma_irq, 0);
        rsp(1'b1, 8'd3, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t1_done_irq", bus.dma_irq, 1);
        chk("t1_done_err", bus.dma_err, 0);
        w1c();
        chk("t1_idle_rdy", bus.dma_ready, 1);
        chk("t1_idle_irq", bus.dma_irq, 0);

        // Unaligned head: 3 words starting one word before a BL boundary.
        job(32'h10F8, 32'h20);
        chk("t2_b0_addr", bus.axaddr, 32'h10F0);
        chk("t2_b0_len",  bus.axlen, 0);
        chk("t2_b0_id",   bus.axid, 0);
        tick();
        chk("t2_b1_addr", bus.axaddr, 32'h1100);
        chk("t2_b1_len",  bus.axlen, 1);
        chk("t2_b1_id",   bus.axid, 1);
        tick();
        chk("t2_resp_valid", bus.axvalid, 0);
        rsp(1'b1, 8'd0, 2'b00, 1'b1);
        tick();
        chk("t2_resp_irq", bus.dma_irq, 0);
        rsp(1'b1, 8'd1, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t2_done_irq", bus.dma_irq, 1);
        chk("t2_done_err", bus.dma_err, 0);
        w1c();

        // 4 KiB job, 16 bursts. Responses are withheld first, then a
        // SLVERR arrives and must stay captured.
        job(32'h2000, 32'h1000);
        chk("t3_b0_addr", bus.axaddr, 32'h2000);
        chk("t3_b0_id",   bus.axid, 2);
        tick();
        chk("t3_b1_addr", bus.axaddr, 32'h2100);
        chk("t3_b1_id",   bus.axid, 3);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_valid", bus.axvalid, 0);
            chk("t3_stall_addr",  bus.axaddr, 32'h2200);
            tick();
        end
        rsp(1'b1, 8'd2, 2'b00, 1'b1);
        tick();
        chk("t3_reissue_valid", bus.axvalid, 1);
        chk("t3_reissue_addr",  bus.axaddr, 32'h2200);
        for (int k = 2; k <= 15; k++) begin
            // Burst k issues while burst k-1 completes.
            rsp(1'b1, 8'((1 + k) % 4), (k == 2) ? 2'b10 : ((k == 6) ? 2'b11 : 2'b00), 1'b1);
            bus.dma_irq_w1c = (k == 5);
            tick();
            if (k < 15) begin
                chk("t4_addr", bus.axaddr, 64'(32'h2000 + (k + 1) * 32'h100));
                chk("t4_id",   bus.axid, 64'((3 + k) % 4));
            end
            chk("t4_err_sticky", bus.dma_err, 4'b0010);
        end
        bus.dma_irq_w1c = 1'b0;
        chk("t4_resp_valid", bus.axvalid, 0);
        chk("t4_resp_irq",   bus.dma_irq, 0);
        rsp(1'b1, 8'd1, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t4_done_irq", bus.dma_irq, 1);
        chk("t4_done_err", bus.dma_err, 4'b0010);
        tick();
        chk("t4_irq_held", bus.dma_irq, 1);
        w1c();
        chk("t4_w1c_rdy", bus.dma_ready, 1);
        chk("t4_w1c_err", bus.dma_err, 0);

        // Out-of-window ID on a non-last beat.
        rsp(1'b1, 8'd4, 2'b00, 1'b0);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t5_badid_err", bus.dma_err, 4'b0100);

        // A zero-length job finishes at once without address activity.
        job(32'h5000, 32'h0);
        chk("t6_len0_irq",   bus.dma_irq, 1);
        chk("t6_len0_valid", bus.axvalid, 0);
        chk("t6_len0_err",   bus.dma_err, 4'b0100);
        w1c();
        chk("t6_len0_clr", bus.dma_err, 0);

        // Unexpected completion while idle: flagged, counter does not wrap.
        rsp(1'b1, 8'd0, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t5_unexp_err", bus.dma_err, 4'b0100);
        job(32'h3000, 32'h10);
        chk("t5_nouf_valid", bus.axvalid, 1);
        chk("t5_nouf_len",   bus.axlen, 0);
        chk("t5_nouf_id",    bus.axid, 2);
        tick();
        chk("t5_nouf_resp", bus.axvalid, 0);
        rsp(1'b1, 8'd2, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t5_nouf_irq", bus.dma_irq, 1);
        chk("t5_nouf_err", bus.dma_err, 4'b0100);
        w1c();
        chk("t5_nouf_clr", bus.dma_err, 0);

        // Reset mid-job, then a straggling response arrives.
        job(32'h4000, 32'h200);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t7_rst_rdy",   bus.dma_ready, 1);
        chk("t7_rst_valid", bus.axvalid, 0);
        chk("t7_rst_err",   bus.dma_err, 0);
        rsp(1'b1, 8'd3, 2'b00, 1'b1);
        tick();
        rsp(1'b0, 8'd0, 2'b00, 1'b1);
        chk("t7_late_err", bus.dma_err, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
